// File: rtl/mpadd_pkg.sv
// Shared types for the multi-word adder: FSM states, select encoding and overflow helper.
// Operand select is 0 for add and 1 for subtract.
package mpadd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic SEL_ADD = 1'b0;
  localparam logic SEL_SUB = 1'b1;

  // Subtract adds ~b, so the effective second operand sign is inverted.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic sub, input logic r_msb);
    logic b_eff;
    b_eff = b_msb ^ sub;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/regadd_word.sv
// regadd_word: N-bit add/subtract slice, a + (sel ? ~b : b) + ci, sum and carry registered.
// Latency 1 cycle; en low holds the registered sum/carry, no other backpressure.
module regadd_word
  import mpadd_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sel,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] sum,
  output logic         co
);

  logic [N-1:0] b_eff;
  logic [N-1:0] sum_d, sum_q;
  logic         co_d, co_q;

  always_comb begin
    b_eff = (sel == SEL_SUB) ? ~b : b;
    {co_d, sum_d} = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, ci};
    if (!en) begin
      sum_d = sum_q;
      co_d  = co_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q <= '0;
      co_q  <= 1'b0;
    end else begin
      sum_q <= sum_d;
      co_q  <= co_d;
    end
  end

  assign sum = sum_q;
  assign co  = co_q;

endmodule

// File: rtl/mpadd_seq.sv
// mpadd_seq: W=N*K bit add/subtract on one registered N-bit slice, LSW first; out_valid K+1 edges after accept.
// Accepts only in IDLE; result held in DONE until out_ready. Define MPADD_SEQ_OVF_EN to add the ovf output.
module mpadd_seq
  import mpadd_pkg::*;
#(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           select,
  input  logic           c_in,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] result,
  output logic           c_out,
`ifdef MPADD_SEQ_OVF_EN
  output logic           ovf,
`endif
  output logic           busy
);

  localparam int W  = N * K;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(K - 1);

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           last_q, last_d;
  logic           pend_q, pend_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic           sel_q, sel_d;
  logic           cin_q, cin_d;
  logic [W-1:0]   result_q, result_d;
  logic           c_out_q, c_out_d;
  logic           out_valid_q, out_valid_d;
  logic           in_ready_q, in_ready_d;
  logic           busy_q, busy_d;
`ifdef MPADD_SEQ_OVF_EN
  logic           ovf_q, ovf_d;
`endif

  logic           slice_en;
  logic [N-1:0]   slice_a, slice_b;
  logic           slice_ci;
  logic [N-1:0]   slice_sum;
  logic           slice_co;
  logic [W-1:0]   sum_ext;

  regadd_word #(.N(N)) u_slice (
    .clk (clk),
    .rst (rst),
    .en  (slice_en),
    .sel (sel_q),
    .a   (slice_a),
    .b   (slice_b),
    .ci  (slice_ci),
    .sum (slice_sum),
    .co  (slice_co)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pend_d      = pend_q;
    a_d         = a_q;
    b_d         = b_q;
    sel_d       = sel_q;
    cin_d       = cin_q;
    result_d    = result_q;
    c_out_d     = c_out_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
`ifdef MPADD_SEQ_OVF_EN
    ovf_d       = ovf_q;
`endif

    slice_en = 1'b0;
    slice_a  = a_q[cnt_q*N +: N];
    slice_b  = b_q[cnt_q*N +: N];
    // Word 0 takes the operation's carry-in; later words chain the registered carry.
    slice_ci = (cnt_q == '0) ? cin_q : slice_co;

    sum_ext = '0;
    sum_ext[W-1 -: N] = slice_sum;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d        = a;
          b_d        = b;
          sel_d      = select;
          cin_d      = c_in ^ (select == SEL_SUB);
          cnt_d      = '0;
          last_d     = 1'b0;
          pend_d     = 1'b0;
          state_d    = RUN;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end
      RUN: begin
        slice_en = !last_q;
        pend_d   = !last_q;
        if (!last_q) begin
          if (cnt_q == LAST_WORD) last_d = 1'b1;
          else                    cnt_d  = cnt_q + 1'b1;
        end
        // Each finished word enters at the top; after K shifts word 0 sits at the bottom.
        if (pend_q) result_d = (result_q >> N) | sum_ext;
        if (last_q) begin
          state_d     = DONE;
          out_valid_d = 1'b1;
          c_out_d     = slice_co;
`ifdef MPADD_SEQ_OVF_EN
          ovf_d       = signed_ovf(a_q[W-1], b_q[W-1], sel_q == SEL_SUB, slice_sum[N-1]);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
          in_ready_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      pend_q      <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= SEL_ADD;
      cin_q       <= 1'b0;
      result_q    <= '0;
      c_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
`ifdef MPADD_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pend_q      <= pend_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sel_q       <= sel_d;
      cin_q       <= cin_d;
      result_q    <= result_d;
      c_out_q     <= c_out_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
`ifdef MPADD_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign c_out     = c_out_q;
  assign busy      = busy_q;
`ifdef MPADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_mpadd_seq.sv
// Bench for mpadd_seq (N=8, K=4): directed vectors plus random traffic against a W-bit arithmetic model.
module tb_mpadd_seq;

  localparam int N = 8;
  localparam int K = 4;
  localparam int W = N * K;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         select;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         c_out;
  logic         busy;
`ifdef MPADD_SEQ_OVF_EN
  logic         ovf;
  logic         last_ovf;
`endif

  always #5 clk = ~clk;

  mpadd_seq #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .select    (select),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .c_out     (c_out),
`ifdef MPADD_SEQ_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic model: plain wide integer math on the whole operands.
  function automatic void calc(input logic [W-1:0] ai, input logic [W-1:0] bi,
                               input logic s, input logic ci,
                               output logic [W-1:0] r, output logic co, output logic ov);
    longint ua, ub, sa, sb, c, t, st;
    ua = longint'(ai);
    ub = longint'(bi);
    sa = longint'(signed'(ai));
    sb = longint'(signed'(bi));
    c  = ci ? 64'sd1 : 64'sd0;
    if (!s) begin
      t  = ua + ub + c;
      co = t[W];
      st = sa + sb + c;
    end else begin
      t  = ua - ub - c;
      co = (t >= 0);
      st = sa - sb - c;
    end
    r  = t[W-1:0];
    ov = (st > 64'sd2147483647) || (st < -64'sd2147483648);
  endfunction

  int           m_phase = 0;
  int           m_left  = 0;
  int           m_hs    = 0;
  int           dut_hs  = 0;
  bit           m_rst_seen = 1'b0;
  logic [W-1:0] m_res = '0, m_pres = '0;
  logic         m_co = 1'b0, m_pco = 1'b0, m_ovf = 1'b0, m_povf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase    = 0;
      m_res      = '0;
      m_co       = 1'b0;
      m_ovf      = 1'b0;
      m_rst_seen = 1'b1;
    end else begin
      if (out_valid && out_ready) dut_hs++;
      case (m_phase)
        0: if (in_valid) begin
             calc(a, b, select, c_in, m_pres, m_pco, m_povf);
             m_phase    = 1;
             m_left     = K + 1;
             m_rst_seen = 1'b0;
           end
        1: begin
             m_left--;
             if (m_left == 0) begin
               m_phase = 2;
               m_res   = m_pres;
               m_co    = m_pco;
               m_ovf   = m_povf;
             end
           end
        default: if (out_ready) begin
             m_phase = 0;
             m_hs++;
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_phase == 0);
      chk("busy", busy, m_phase != 0);
      chk("out_valid", out_valid, m_phase == 2);
      if (m_phase == 2 || m_rst_seen) begin
        chk("result", result, m_res);
        chk("c_out", c_out, m_co);
`ifdef MPADD_SEQ_OVF_EN
        chk("ovf", ovf, m_ovf);
`endif
      end
    end
  end

  // Present a request and return #1 after the accepting edge with the inputs scrambled.
  task automatic issue(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic s, input logic ci);
    int n = 0;
    a = ai; b = bi; select = s; c_in = ci; in_valid = 1'b1;
    while (!in_ready && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept wait", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~ai; b = ~bi; select = ~s; c_in = ~ci;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] ai, input logic [W-1:0] bi,
                        input logic s, input logic ci, input logic [W-1:0] er, input logic eco);
    int lat;
    issue(ai, bi, s, ci);
    wait_valid(lat);
    chk({name, " latency"}, lat, K + 1);
    chk({name, " result"}, result, er);
    chk({name, " c_out"}, c_out, eco);
`ifdef MPADD_SEQ_OVF_EN
    last_ovf = ovf;
`endif
    @(posedge clk); #1;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    int cyc;
    int target;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; select = 1'b0; c_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset in_ready", in_ready, 1'b1);
    chk("reset result", result, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("add wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
    run_op("sub borrow", 32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0);
    run_op("sub bin", 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0001, 1'b1);

    // Backpressure with a second request pulsed while the first result is held.
    out_ready = 1'b0;
    issue(32'h0000_1000, 32'h0000_0234, 1'b0, 1'b0);
    wait_valid(lat);
    chk("bp latency", lat, K + 1);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0000_0001; select = 1'b0; c_in = 1'b0;
      @(posedge clk); #1;
      chk("bp held result", result, 32'h0000_1234);
      chk("bp in_ready", in_ready, 1'b0);
      chk("bp out_valid", out_valid, 1'b1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp in_ready after handshake", in_ready, 1'b1);
    chk("bp busy after handshake", busy, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp second accepted", busy, 1'b1);
    wait_valid(lat);
    chk("bp second latency", lat, K + 1);
    chk("bp second result", result, 32'hDEAD_BEF0);
    @(posedge clk); #1;

    // Reset once three words are registered.
    issue(32'hAAAA_5555, 32'h1234_5678, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort out_valid", out_valid, 1'b0);
    chk("abort result", result, 32'h0);
    chk("abort in_ready", in_ready, 1'b1);
    run_op("after abort", 32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0);

`ifdef MPADD_SEQ_OVF_EN
    run_op("ovf pos", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0);
    chk("ovf pos flag", last_ovf, 1'b1);
    run_op("ovf none", 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0);
    chk("ovf none flag", last_ovf, 1'b0);
`endif

    // Random traffic: every cycle gets fresh inputs and a random out_ready.
    cyc = 0;
    target = dut_hs + 1000;
    while (dut_hs < target && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = pick();
      b         = pick();
      select    = $urandom_range(0, 1);
      c_in      = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk); #1;
      cyc++;
    end
    chk("random ops completed", dut_hs >= target, 1'b1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("handshake count", dut_hs, m_hs);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
